// File: rtl/controlador_pkg.sv
// Shared definitions for the instruction-source controller: FSM encoding,
// opcode constants, well-known source indices and a select-width helper.
package controlador_pkg;

    // Controller states; values are fixed so waveforms read the same across builds.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        STOP  = 2'd2
    } estado_t;

    // Opcode that terminates the current source, and the opcode of the NOP
    // presented while flushing or stopped.
    localparam logic [5:0] OPCODE_HALT = 6'b011000;
    localparam logic [5:0] OPCODE_NOP  = 6'b000000;

    // Conventional meaning of the first source indices.
    localparam int FONTE_BIOS    = 0;
    localparam int FONTE_SO      = 1;
    localparam int FONTE_USUARIO = 2;

    // Width of a source index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_fontes.sv
// N-way instruction mux over a packed bus, with a force-to-zero enable used
// to present NOPs while the controller is flushing or stopped.
module mux_fontes #(
    parameter int DATA_WIDTH = 32,
    parameter int N_SOURCES  = 3,
    parameter int SEL_W      = 2
) (
    input  logic [N_SOURCES*DATA_WIDTH-1:0] fontes_i,
    input  logic [SEL_W-1:0]                sel_i,
    input  logic                            zera_i,
    output logic [DATA_WIDTH-1:0]           dado_o
);

    // Pick the selected slice; an out-of-range select or zera_i yields all zeros.
    always_comb begin
        // NOTE: assigning a default before any branch keeps this purely
        // combinational; a path that leaves dado_o unassigned would infer a latch.
        dado_o = '0;
        if (!zera_i) begin
            for (int k = 0; k < N_SOURCES; k++) begin
                if (sel_i == SEL_W'(k)) begin
                    dado_o = fontes_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/controlador_fontes_instrucao.sv
// Instruction-source controller: feeds the CPU from one of N_SOURCES streams,
// advances on HALT, honours explicit switch requests, and wraps every source
// change in a RESET_CYCLES-long CPU reset / NOP flush window.
module controlador_fontes_instrucao
    import controlador_pkg::*;
#(
    parameter int         DATA_WIDTH   = 32,
    parameter int         N_SOURCES    = 3,
    parameter int         OPCODE_MSB   = 31,
    parameter logic [5:0] HALT_OPCODE  = OPCODE_HALT,
    parameter int         RESET_CYCLES = 4,
    localparam int        SEL_W        = sel_width(N_SOURCES)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_SOURCES*DATA_WIDTH-1:0] fontes,
    input  logic                            switch_req,
    input  logic [SEL_W-1:0]                switch_target,
    output logic [DATA_WIDTH-1:0]           instrucao,
    output logic [SEL_W-1:0]                fonte_atual,
    output logic                            cpu_reset,
    output logic                            parado,
    output logic                            switch_ack,
    output logic                            switch_err
);

    localparam int               CNT_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CONT_INI  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [SEL_W-1:0] ULTIMA    = SEL_W'(N_SOURCES - 1);
    localparam logic [SEL_W:0]   N_SRC_EXT = (SEL_W + 1)'(N_SOURCES);

    estado_t          estado_q, estado_d;
    logic [SEL_W-1:0] fonte_q, fonte_d;
    logic [CNT_W-1:0] cont_q, cont_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             parado_q, parado_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             halt;
    logic             alvo_valido;

    // Outside RUN the CPU sees NOPs, which also stops HALT from re-triggering.
    mux_fontes #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_SOURCES  (N_SOURCES),
        .SEL_W      (SEL_W)
    ) u_mux (
        .fontes_i (fontes),
        .sel_i    (fonte_q),
        .zera_i   (estado_q != RUN),
        .dado_o   (instrucao)
    );

    assign halt        = (estado_q == RUN) && (instrucao[OPCODE_MSB -: 6] == HALT_OPCODE);
    assign alvo_valido = ({1'b0, switch_target} < N_SRC_EXT);

    // Next-state and registered-output logic; HALT has priority over a request.
    always_comb begin
        estado_d    = estado_q;
        fonte_d     = fonte_q;
        cont_d      = cont_q;
        cpu_reset_d = cpu_reset_q;
        parado_d    = parado_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;

        unique case (estado_q)
            RUN: begin
                if (halt) begin
                    if (fonte_q != ULTIMA) begin
                        fonte_d     = fonte_q + SEL_W'(1);
                        estado_d    = FLUSH;
                        cont_d      = CONT_INI;
                        cpu_reset_d = 1'b1;
                    end else begin
                        estado_d = STOP;
                        parado_d = 1'b1;
                    end
                end else if (switch_req) begin
                    if (alvo_valido) begin
                        fonte_d     = switch_target;
                        estado_d    = FLUSH;
                        cont_d      = CONT_INI;
                        cpu_reset_d = 1'b1;
                        ack_d       = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            FLUSH: begin
                // Requests arriving during the flush window are ignored outright.
                if (cont_q == '0) begin
                    estado_d    = RUN;
                    cpu_reset_d = 1'b0;
                end else begin
                    cont_d = cont_q - CNT_W'(1);
                end
            end

            STOP: begin
                if (switch_req) begin
                    if (alvo_valido) begin
                        fonte_d     = switch_target;
                        estado_d    = FLUSH;
                        cont_d      = CONT_INI;
                        cpu_reset_d = 1'b1;
                        parado_d    = 1'b0;
                        ack_d       = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            default: begin
                estado_d    = RUN;
                cpu_reset_d = 1'b0;
                parado_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset returns to RUN on the BIOS.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= RUN;
            fonte_q     <= SEL_W'(FONTE_BIOS);
            cont_q      <= '0;
            cpu_reset_q <= 1'b0;
            parado_q    <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the same pre-edge values, independent of statement order.
            estado_q    <= estado_d;
            fonte_q     <= fonte_d;
            cont_q      <= cont_d;
            cpu_reset_q <= cpu_reset_d;
            parado_q    <= parado_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign fonte_atual = fonte_q;
    assign cpu_reset   = cpu_reset_q;
    assign parado      = parado_q;
    assign switch_ack  = ack_q;
    assign switch_err  = err_q;

endmodule

// File: tb/tb_controlador_fontes_instrucao.sv
// Scoreboard bench for the instruction-source controller. Two instances run
// side by side (3 sources / 4-cycle flush, and 2 sources / 1-cycle flush);
// sel_b chooses which one the monitor compares.
module tb_controlador_fontes_instrucao;

    localparam logic [31:0] HALT = 32'h6000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  fonte;
        logic        rst;
        logic        par;
        logic        ack;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [95:0] fontes;
    logic        switch_req;
    logic [1:0]  switch_target;
    logic        sel_b;

    logic [31:0] instr_a, instr_b;
    logic [1:0]  fonte_a;
    logic        fonte_b;
    logic        rst_a, rst_b, par_a, par_b, ack_a, ack_b, err_a, err_b;

    // Next-cycle stimulus, applied by ciclo()
    logic [31:0] b0_n, b1_n, b2_n;
    logic        rst_n_n;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    controlador_fontes_instrucao dut_a (
        .clock         (clock),
        .reset         (reset),
        .fontes        (fontes),
        .switch_req    (switch_req),
        .switch_target (switch_target),
        .instrucao     (instr_a),
        .fonte_atual   (fonte_a),
        .cpu_reset     (rst_a),
        .parado        (par_a),
        .switch_ack    (ack_a),
        .switch_err    (err_a)
    );

    controlador_fontes_instrucao #(
        .N_SOURCES    (2),
        .RESET_CYCLES (1)
    ) dut_b (
        .clock         (clock),
        .reset         (reset),
        .fontes        (fontes[63:0]),
        .switch_req    (switch_req),
        .switch_target (switch_target[0]),
        .instrucao     (instr_b),
        .fonte_atual   (fonte_b),
        .cpu_reset     (rst_b),
        .parado        (par_b),
        .switch_ack    (ack_b),
        .switch_err    (err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: each negedge compares the outputs against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("instrucao",   sel_b ? instr_b : instr_a, e.instr);
            check("fonte_atual", sel_b ? 32'(fonte_b) : 32'(fonte_a), 32'(e.fonte));
            check("cpu_reset",   32'(sel_b ? rst_b : rst_a), 32'(e.rst));
            check("parado",      32'(sel_b ? par_b : par_a), 32'(e.par));
            check("switch_ack",  32'(sel_b ? ack_b : ack_a), 32'(e.ack));
            check("switch_err",  32'(sel_b ? err_b : err_a), 32'(e.err));
        end
    end

    // Apply one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic ciclo(input logic req, input logic [1:0] tgt,
                         input logic [31:0] e_instr, input logic [1:0] e_fonte,
                         input logic e_rst, input logic e_par,
                         input logic e_ack, input logic e_err);
        exp_t e;
        @(negedge clock);
        #1;
        reset         = rst_n_n;
        fontes        = {b2_n, b1_n, b0_n};
        switch_req    = req;
        switch_target = tgt;
        e.instr = e_instr;
        e.fonte = e_fonte;
        e.rst   = e_rst;
        e.par   = e_par;
        e.ack   = e_ack;
        e.err   = e_err;
        sb.push_back(e);
    endtask

    task automatic run(input int n, input logic [31:0] ins, input logic [1:0] f);
        repeat (n) ciclo(1'b0, 2'd0, ins, f, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush(input int n, input logic [1:0] f, input logic req, input logic [1:0] tgt);
        repeat (n) ciclo(req, tgt, 32'h0, f, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stop(input int n, input logic [1:0] f);
        repeat (n) ciclo(1'b0, 2'd0, 32'h0, f, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Assert reset mid-cycle and confirm the registered outputs clear at once.
    task automatic reset_mid();
        @(negedge clock);
        #1;
        rst_n_n = 1'b0;
        b0_n    = 32'h1;
        reset   = 1'b0;
        fontes  = {b2_n, b1_n, b0_n};
        #1;
        check("rst_async_cpu_reset", 32'(sel_b ? rst_b : rst_a), 32'h0);
        check("rst_async_fonte", sel_b ? 32'(fonte_b) : 32'(fonte_a), 32'h0);
        check("rst_async_instr", sel_b ? instr_b : instr_a, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rst_n_n = 1'b0; sel_b = 1'b0;
        fontes = '0; switch_req = 1'b0; switch_target = 2'd0;
        b0_n = 32'h1; b1_n = 32'h11; b2_n = 32'h22;

        // ---------------- 3 sources, 4-cycle flush ----------------
        repeat (3) ciclo(1'b0, 2'd0, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n_n = 1'b1;
        run(2, 32'h1, 2'd0);

        // HALT on BIOS: source 1 after exactly 4 reset cycles
        b0_n = HALT;
        flush(4, 2'd1, 1'b0, 2'd0);
        b0_n = 32'h1;
        run(2, 32'h11, 2'd1);

        // HALT on OS, then HALT on the last source stops the controller
        b1_n = HALT;
        flush(4, 2'd2, 1'b0, 2'd0);
        b1_n = 32'h11;
        run(2, 32'h22, 2'd2);
        b2_n = HALT;
        stop(11, 2'd2);
        b2_n = 32'h22;
        ciclo(1'b1, 2'd1, 32'h0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        flush(3, 2'd1, 1'b0, 2'd0);
        run(2, 32'h11, 2'd1);

        // Invalid target: error pulse only
        ciclo(1'b1, 2'd3, 32'h11, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        run(2, 32'h11, 2'd1);

        // Restart of the current source, then explicit jump back to BIOS
        ciclo(1'b1, 2'd1, 32'h0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        flush(3, 2'd1, 1'b0, 2'd0);
        run(1, 32'h11, 2'd1);
        ciclo(1'b1, 2'd0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        flush(3, 2'd0, 1'b0, 2'd0);
        run(2, 32'h1, 2'd0);

        // HALT and request together: HALT wins, held request accepted after flush
        b0_n = HALT;
        ciclo(1'b1, 2'd0, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        flush(3, 2'd1, 1'b1, 2'd0);
        b0_n = 32'h1;
        ciclo(1'b1, 2'd0, 32'h11, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 2'd0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        flush(3, 2'd0, 1'b0, 2'd0);
        run(2, 32'h1, 2'd0);

        // Reset during the second flush cycle
        b0_n = HALT;
        flush(2, 2'd1, 1'b0, 2'd0);
        reset_mid();
        repeat (2) ciclo(1'b0, 2'd0, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n_n = 1'b1;
        run(2, 32'h1, 2'd0);

        // ---------------- 2 sources, 1-cycle flush ----------------
        @(negedge clock);
        sel_b = 1'b1;
        rst_n_n = 1'b0;
        repeat (3) ciclo(1'b0, 2'd0, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n_n = 1'b1;
        run(2, 32'h1, 2'd0);

        b0_n = HALT;
        flush(1, 2'd1, 1'b0, 2'd0);
        b0_n = 32'h1;
        run(2, 32'h11, 2'd1);

        b1_n = HALT;
        stop(4, 2'd1);
        b1_n = 32'h11;
        ciclo(1'b1, 2'd0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        run(2, 32'h1, 2'd0);

        ciclo(1'b1, 2'd0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        run(1, 32'h1, 2'd0);

        b0_n = HALT;
        ciclo(1'b1, 2'd0, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        b0_n = 32'h1;
        ciclo(1'b1, 2'd0, 32'h11, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 2'd0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        run(2, 32'h1, 2'd0);

        b0_n = HALT;
        flush(1, 2'd1, 1'b0, 2'd0);
        reset_mid();
        ciclo(1'b0, 2'd0, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n_n = 1'b1;
        run(2, 32'h1, 2'd0);

        @(negedge clock);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/controlador_fontes_instrucao.md
Name: controlador_fontes_instrucao

Overview:
Parametrised instruction-source controller; successor to the single BIOS→memory switch. It selects one of N_SOURCES instruction streams (BIOS, OS, user program, …) to feed the CPU fetch path. On a HALT opcode it advances to the next source. It also accepts explicit switch requests from the OS/interrupt logic. Every source change issues a multi-cycle CPU reset pulse and a flush window during which only NOPs are presented.

Parameters:
DATA_WIDTH, 32, instruction width
N_SOURCES, 3, number of instruction sources (≥2); source 0 = BIOS
OPCODE_MSB, 31, top bit of the 6-bit opcode field (opcode = instrucao[OPCODE_MSB -: 6])
HALT_OPCODE, 6'b011000, opcode that ends the current source
RESET_CYCLES, 4, length of cpu_reset pulse / flush window (≥1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low global reset
fontes  in  N_SOURCES*DATA_WIDTH  packed instruction buses; source k at [k*DATA_WIDTH +: DATA_WIDTH]
switch_req  in  1  request to jump to switch_target
switch_target  in  SEL_W  requested source index; SEL_W = max(1,$clog2(N_SOURCES))
instrucao  out  DATA_WIDTH  effective instruction to CPU
fonte_atual  out  SEL_W  index of active source
cpu_reset  out  1  active-high CPU/PC reset pulse
parado  out  1  high while in STOP
switch_ack  out  1  one-cycle pulse: request accepted
switch_err  out  1  one-cycle pulse: request rejected (target ≥ N_SOURCES)

Behaviour:
- States: RUN, FLUSH, STOP. On reset low (async): state=RUN, fonte_atual=0, count=0; cpu_reset, parado, switch_ack, switch_err all 0.
- instrucao is combinational:
  - RUN: selected source bus.
  - FLUSH or STOP: all-zero (NOP), so HALT cannot be re-detected.
- HALT detection uses opcode of instrucao, evaluated only in RUN.
- RUN, opcode==HALT:
  - fonte_atual<N_SOURCES-1: next edge sets fonte_atual+1, state=FLUSH, count=RESET_CYCLES-1, cpu_reset=1.
  - fonte_atual==N_SOURCES-1: next edge sets state=STOP, parado=1.
- RUN, switch_req with no HALT:
  - Target valid (<N_SOURCES), including target==fonte_atual (restart): next edge sets fonte_atual=target, FLUSH, cpu_reset=1, switch_ack=1 for that cycle.
  - Target invalid: switch_err=1 for one cycle; state unchanged.
- HALT and switch_req in the same cycle: HALT wins. No ack and no err that cycle; requester must hold switch_req.
- FLUSH:
  - cpu_reset stays 1.
  - count decrements each cycle. When count==0, next edge sets RUN and cpu_reset=0.
  - cpu_reset is high for exactly RESET_CYCLES cycles.
  - switch_req is ignored (no ack, no err).
- STOP:
  - parado=1 and instrucao=0.
  - Only a valid switch_req leaves STOP: goes to FLUSH with ack (parado falls on the same edge).
  - Invalid target gives switch_err.
- switch_ack and switch_err are registered single-cycle pulses; they never assert together.
- Reset asserted mid-FLUSH: immediate return to RUN/source 0; cpu_reset drops asynchronously.
- All outputs except instrucao are registered. Latency from HALT in RUN to cpu_reset high is 1 cycle.

Decomposition:
- Shared package `controlador_pkg`:
  - state encoding localparams (RUN=2'd0, FLUSH=2'd1, STOP=2'd2)
  - HALT and NOP opcode constants
  - source index constants (FONTE_BIOS=0, FONTE_SO=1, FONTE_USUARIO=2)
- One sub-module, `mux_fontes`: parametrised N-way DATA_WIDTH mux from the packed bus with a force-zero enable. The FSM and counter stay in the top module.

Test Plan:
1. Reset low 3 cycles, release, BIOS bus=32'h0000_0001 → instrucao=32'h1, fonte_atual=0, cpu_reset=0, parado=0.
2. BIOS bus=32'h6000_0000 (HALT) in RUN → next cycle fonte_atual=1, cpu_reset=1 for exactly 4 cycles, instrucao=0 throughout; then instrucao=OS bus.
3. HALT on source 2 (last) → parado=1, instrucao=0; hold 10 cycles, no change. Then switch_req target=1 → switch_ack pulse, FLUSH 4 cycles, RUN on source 1.
4. switch_req target=3 with N_SOURCES=3 → switch_err one cycle, fonte_atual unchanged, no cpu_reset.
5. HALT and switch_req target=0 same cycle on source 0 → source 1 selected, no ack. Request held through FLUSH is ignored, then accepted first RUN cycle: ack, source 0, new 4-cycle flush.
6. Reset low during cycle 2 of FLUSH → cpu_reset falls immediately; after release, fonte_atual=0, RUN. Repeat the suite with RESET_CYCLES=1 and N_SOURCES=2.
